// File: rtl/mul_div_unit_if.sv
// EX <-> mul/div unit handshake bundle: operand request side and {HI,LO} result side.
interface mul_div_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        busy;

  modport master (
    output in_valid, op, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, out_hi, out_lo, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS32 MULT/MULTU/DIV/DIVU unit producing {HI,LO}; pipelined multiply, radix-2 restoring divide.
// Build option MDU_DIV_EARLY_EN: finish divides with |divisor| > |dividend| in one edge.
module mul_div_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned MUL_STG  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [4:0]  MUL_LAST = 5'(MUL_LAT - 1);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        accept;

  logic        op_signed;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_raw;
  logic [31:0] b_raw;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic [63:0] mul_stage [MUL_STG];

  logic        in_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] product;
  logic [63:0] mul_last;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic        q_bit;
  logic [32:0] rem_next;
  logic        div_zero;
  logic        early_hit;

  assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
  assign in_signed = ~bus.op[0];
  assign abs_a     = (in_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign abs_b     = (in_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // Low 64 bits of the 33x33 extended product equal a 64x64 multiply of the extended operands.
  assign product  = {{32{op_signed & a_raw[31]}}, a_raw} * {{32{op_signed & b_raw[31]}}, b_raw};
  assign mul_last = (MUL_LAT == 1) ? product : mul_stage[MUL_STG-1];

  assign shifted  = {rem, quo[31]};
  assign trial    = shifted - {2'b00, dvs};
  assign q_bit    = ~trial[33];
  assign rem_next = q_bit ? trial[32:0] : shifted[32:0];
  assign div_zero = (dvs == '0);

`ifdef MDU_DIV_EARLY_EN
  assign early_hit = (dvs > quo);
`else
  assign early_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    if (bus.flush && state != S_IDLE) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) next_state = bus.op[1] ? S_DIV : S_MUL;
        S_MUL:  if (cnt == MUL_LAST) next_state = S_DONE;
        S_DIV: begin
          if (cnt == '0 && (div_zero || early_hit)) next_state = S_DONE;
          else if (cnt == 5'd31)                     next_state = S_SIGN;
        end
        S_SIGN: next_state = S_DONE;
        S_DONE: if (bus.out_ready) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= next_state;
      bus.in_ready  <= (next_state == S_IDLE);
      bus.busy      <= (next_state != S_IDLE);
      bus.out_valid <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_hi <= '0;
      bus.out_lo <= '0;
      op_signed  <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      a_raw      <= '0;
      b_raw      <= '0;
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cnt        <= '0;
      for (int unsigned i = 0; i < MUL_STG; i++) mul_stage[i] <= '0;
    end else if (!bus.flush) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_raw     <= bus.src_a;
            b_raw     <= bus.src_b;
            op_signed <= in_signed;
            neg_q     <= in_signed & (bus.src_a[31] ^ bus.src_b[31]);
            neg_r     <= in_signed & bus.src_a[31];
            quo       <= abs_a;
            dvs       <= abs_b;
            rem       <= '0;
            cnt       <= '0;
          end
        end
        S_MUL: begin
          mul_stage[0] <= product;
          for (int unsigned i = 1; i < MUL_STG; i++) mul_stage[i] <= mul_stage[i-1];
          cnt <= cnt + 5'd1;
          if (cnt == MUL_LAST) {bus.out_hi, bus.out_lo} <= mul_last;
        end
        S_DIV: begin
          if (cnt == '0 && div_zero) begin
            bus.out_lo <= '1;
            bus.out_hi <= a_raw;
          end else if (cnt == '0 && early_hit) begin
            bus.out_lo <= '0;
            bus.out_hi <= a_raw;
          end else begin
            rem <= rem_next;
            quo <= {quo[30:0], q_bit};
            cnt <= cnt + 5'd1;
          end
        end
        S_SIGN: begin
          bus.out_lo <= neg_q ? -quo : quo;
          bus.out_hi <= neg_r ? -rem[31:0] : rem[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit: results, latencies, hold, flush and reset abort.
module tb_mul_div_unit;

  localparam int unsigned MUL_LAT = 2;
`ifdef MDU_DIV_EARLY_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mul_div_unit_if bus();

  mul_div_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready) begin
        rdy = 1;
        break;
      end
      tick();
    end
    check("in_ready_wait", 64'(rdy), 64'd1);
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input int hold, input string tag);
    int lat = 0;
    bit seen = 0;
    start_op(v.op, v.a, v.b);
    for (int k = 0; k < 60; k++) begin
      tick();
      lat++;
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(v.lat));
    check({tag, "_hi"}, 64'(bus.out_hi), 64'(v.hi));
    check({tag, "_lo"}, 64'(bus.out_lo), 64'(v.lo));
    check({tag, "_busy_rdy"}, {62'd0, bus.busy, bus.in_ready}, 64'd2);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold"}, {bus.out_valid, bus.out_hi, bus.out_lo}, {1'b1, v.hi, v.lo});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         32'h1,         2};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        33};
    vecs[5]  = '{2'b11, 32'd100,       32'd0,          32'd100,       32'hFFFF_FFFF, 1};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000, 33};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{2'b11, 32'h1234_5678, 32'h0000_1000,  32'h0000_0678, 32'h0001_2345, 33};
    vecs[10] = '{2'b10, 32'hFFFF_FFFD, 32'd10,         32'hFFFF_FFFD, 32'h0,         EARLY_LAT};
    vecs[11] = '{2'b01, 32'h0001_0000, 32'h0003_0000,  32'h0000_0003, 32'h0,         2};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("reset_state",
          {bus.in_ready, bus.out_valid, bus.busy, bus.out_hi, bus.out_lo},
          {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], i % 3, $sformatf("vec%0d", i));
    end

    // DIV 1000/3 killed on E10: nothing may come out, unit idle right after.
    start_op(2'b10, 32'd1000, 32'd3);
    for (int k = 1; k < 10; k++) begin
      tick();
      check("flush_pre", {62'd0, bus.out_valid, bus.busy}, 64'd1);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_after", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd1);
    repeat (40) begin
      tick();
      if (bus.out_valid) check("flush_no_result", 64'(bus.out_valid), 64'd0);
    end
    v = '{2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 2};
    run_op(v, 0, "post_flush_mul");

    // DIVU 3/10 with the consumer stalled for 5 cycles.
    v = '{2'b11, 32'd3, 32'd10, 32'd3, 32'd0, EARLY_LAT};
    run_op(v, 5, "divu_hold");

    // Reset mid-multiply aborts with no output and clears the result registers.
    start_op(2'b01, 32'd9, 32'd9);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("reset_abort",
          {bus.in_ready, bus.out_valid, bus.busy, bus.out_hi, bus.out_lo},
          {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
    repeat (4) begin
      tick();
      if (bus.out_valid) check("reset_abort_quiet", 64'(bus.out_valid), 64'd0);
    end

    // Operation presented while busy must be ignored until in_ready returns.
    start_op(2'b11, 32'd50, 32'd5);
    bus.op       = 2'b01;
    bus.src_a    = 32'd2;
    bus.src_b    = 32'd3;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    check("busy_ignore", {bus.out_valid, bus.out_hi, bus.out_lo}, {1'b1, 32'd0, 32'd10});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("busy_ignore_release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
